// File: rtl/usb_defs.sv
// Shared constants and encodings for the USB receive path.
package usb_defs;

  // Default clocks per bit at 48 MHz
  localparam int LS_CLKS_PER_BIT = 32;
  localparam int FS_CLKS_PER_BIT = 4;

  // Half-bit reload values used to centre the sample after a line transition
  localparam int LS_HALF_CLKS = 16;
  localparam int FS_HALF_CLKS = 2;

  // Width of the bit-timing down-counter
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SYNC      = 2'd1,
    ST_DATA      = 2'd2,
    ST_WAIT_IDLE = 2'd3
  } rx_state_e;

  typedef enum logic [1:0] {
    LINE_SE0 = 2'd0,
    LINE_J   = 2'd1,
    LINE_K   = 2'd2
  } line_e;

  // dp=dm (both low or both high) is SE0; J polarity depends on speed.
  function automatic line_e line_of(input logic dp, input logic dm, input logic fs);
    if (dp == dm)
      return LINE_SE0;
    else if (fs ? dp : dm)
      return LINE_J;
    else
      return LINE_K;
  endfunction

endpackage

// File: rtl/usb_rx_bitclk.sv
// Bit-timing recovery: realigns on every line transition and emits one
// sample strobe per bit period, centred in the bit.
module usb_rx_bitclk
  import usb_defs::*;
#(
  parameter int LS_BIT  = LS_CLKS_PER_BIT,
  parameter int FS_BIT  = FS_CLKS_PER_BIT,
  parameter int LS_HALF = LS_HALF_CLKS,
  parameter int FS_HALF = FS_HALF_CLKS
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_speed,
  input  line_e i_line,
  output logic  o_sample
);

  // The counter strobes on reaching zero, so loading N-1 gives a strobe
  // every N clocks (N = half period after an edge, full period otherwise).
  localparam logic [CNT_W-1:0] LS_BIT_LD  = CNT_W'(LS_BIT - 1);
  localparam logic [CNT_W-1:0] FS_BIT_LD  = CNT_W'(FS_BIT - 1);
  localparam logic [CNT_W-1:0] LS_HALF_LD = CNT_W'(LS_HALF - 1);
  localparam logic [CNT_W-1:0] FS_HALF_LD = CNT_W'(FS_HALF - 1);

  logic [CNT_W-1:0] r_cnt;
  line_e            r_line_prev;
  logic             w_edge;

  assign w_edge = (i_line != r_line_prev);

  // A strobe that coincides with an edge would sample the new bit at its
  // boundary, so it is suppressed; the edge reload takes over.
  assign o_sample = (r_cnt == '0) && !w_edge;

  // Down-counter: half-bit reload on a transition, full-bit reload at zero.
  // Speed is only consulted at a reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt       <= LS_BIT_LD;
      r_line_prev <= LINE_SE0;
    end else begin
      r_line_prev <= i_line;
      if (w_edge)
        r_cnt <= i_speed ? FS_HALF_LD : LS_HALF_LD;
      else if (r_cnt == '0)
        r_cnt <= i_speed ? FS_BIT_LD : LS_BIT_LD;
      else
        r_cnt <= r_cnt - 1'b1;
    end
  end

endmodule

// File: rtl/usb_rx.sv
// USB low/full-speed receiver: NRZI decode, SYNC/EOP detection, bit
// unstuffing and byte assembly on top of the usb_rx_bitclk sampler.
//
// state      | meaning
// -----------+-------------------------------------------------------------
// IDLE       | bus idle; waiting for J then K to start a SYNC
// SYNC       | counting decoded 0s of the SYNC field, waiting for K K
// DATA       | packet active; unstuffing and assembling bytes, watching EOP
// WAIT_IDLE  | after an error; waiting for two consecutive J samples
module usb_rx
  import usb_defs::*;
#(
  parameter int LS_BIT_CLKS = LS_CLKS_PER_BIT,
  parameter int FS_BIT_CLKS = FS_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       usb_speed,
  input  logic       usb_tx_oe,
  input  logic       usb_rx_dp,
  input  logic       usb_rx_dm,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_active,
  output logic       rx_eop,
  output logic       rx_error,
  output logic       rx_bit_pulse
);

  logic      r_dp_meta, r_dp_sync, r_dm_meta, r_dm_sync;
  line_e     w_line;
  logic      w_sample;
  logic      w_is_k, w_bit;

  rx_state_e r_state, w_state_nxt;
  logic      r_prev_k, w_prev_k_nxt;
  logic      r_seen_j, w_seen_j_nxt;
  logic      r_j_once, w_j_once_nxt;
  logic [1:0] r_zeros, w_zeros_nxt;
  logic [2:0] r_ones, w_ones_nxt;
  logic [1:0] r_se0_cnt, w_se0_cnt_nxt;
  logic [2:0] r_bitcnt, w_bitcnt_nxt;
  logic [7:0] r_shift, w_shift_nxt;
  logic [7:0] r_data, w_data_nxt;
  logic      r_valid, w_valid_nxt;
  logic      r_active, w_active_nxt;
  logic      r_eop, w_eop_nxt;
  logic      r_error, w_error_nxt;

  // Two-flop synchronizers for the asynchronous pad inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_meta <= 1'b0;
      r_dp_sync <= 1'b0;
      r_dm_meta <= 1'b0;
      r_dm_sync <= 1'b0;
    end else begin
      r_dp_meta <= usb_rx_dp;
      r_dp_sync <= r_dp_meta;
      r_dm_meta <= usb_rx_dm;
      r_dm_sync <= r_dm_meta;
    end
  end

  assign w_line = line_of(r_dp_sync, r_dm_sync, usb_speed);

  usb_rx_bitclk #(
    .LS_BIT  (LS_BIT_CLKS),
    .FS_BIT  (FS_BIT_CLKS),
    .LS_HALF (LS_BIT_CLKS / 2),
    .FS_HALF (FS_BIT_CLKS / 2)
  ) u_bitclk (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_speed  (usb_speed),
    .i_line   (w_line),
    .o_sample (w_sample)
  );

  // NRZI: same J/K as the previous sample is a 1, a change is a 0
  assign w_is_k = (w_line == LINE_K);
  assign w_bit  = (w_is_k == r_prev_k);

  // Next-state, datapath and output pulse decisions for each sample
  always_comb begin
    w_state_nxt   = r_state;
    w_prev_k_nxt  = r_prev_k;
    w_seen_j_nxt  = r_seen_j;
    w_j_once_nxt  = r_j_once;
    w_zeros_nxt   = r_zeros;
    w_ones_nxt    = r_ones;
    w_se0_cnt_nxt = r_se0_cnt;
    w_bitcnt_nxt  = r_bitcnt;
    w_shift_nxt   = r_shift;
    w_data_nxt    = r_data;
    w_valid_nxt   = 1'b0;
    w_active_nxt  = r_active;
    w_eop_nxt     = 1'b0;
    w_error_nxt   = 1'b0;

    if (w_sample) begin
      if (w_line != LINE_SE0)
        w_prev_k_nxt = w_is_k;

      case (r_state)
        ST_IDLE: begin
          w_active_nxt = 1'b0;
          if (w_line == LINE_J) begin
            w_seen_j_nxt = 1'b1;
          end else if (w_line == LINE_K && r_seen_j) begin
            // This K is itself the first decoded 0 of the SYNC field
            w_state_nxt = ST_SYNC;
            w_zeros_nxt = 2'd1;
          end
        end

        ST_SYNC: begin
          if (w_line == LINE_SE0) begin
            w_state_nxt  = ST_IDLE;
            w_seen_j_nxt = 1'b0;
          end else if (!w_bit) begin
            w_zeros_nxt = (r_zeros == 2'd3) ? 2'd3 : r_zeros + 2'd1;
          end else if (w_is_k && r_zeros == 2'd3) begin
            // Stuffing count starts fresh with the first data bit
            w_state_nxt   = ST_DATA;
            w_active_nxt  = 1'b1;
            w_ones_nxt    = 3'd0;
            w_bitcnt_nxt  = 3'd0;
            w_se0_cnt_nxt = 2'd0;
          end else begin
            w_zeros_nxt = 2'd0;
          end
        end

        ST_DATA: begin
          if (w_line == LINE_SE0) begin
            if (r_se0_cnt == 2'd3) begin
              // Fourth SE0 sample with no J: not an EOP
              w_error_nxt  = 1'b1;
              w_active_nxt = 1'b0;
              w_state_nxt  = ST_WAIT_IDLE;
              w_j_once_nxt = 1'b0;
            end else begin
              w_se0_cnt_nxt = r_se0_cnt + 2'd1;
            end
          end else if (r_se0_cnt != 2'd0) begin
            w_se0_cnt_nxt = 2'd0;
            w_active_nxt  = 1'b0;
            if (w_line == LINE_J) begin
              w_eop_nxt    = (r_bitcnt == 3'd0);
              w_error_nxt  = (r_bitcnt != 3'd0);
              w_state_nxt  = ST_IDLE;
              w_seen_j_nxt = 1'b1;
            end else begin
              w_error_nxt  = 1'b1;
              w_state_nxt  = ST_WAIT_IDLE;
              w_j_once_nxt = 1'b0;
            end
          end else if (r_ones == 3'd6) begin
            if (!w_bit) begin
              w_ones_nxt = 3'd0;
            end else begin
              w_error_nxt  = 1'b1;
              w_active_nxt = 1'b0;
              w_state_nxt  = ST_WAIT_IDLE;
              w_j_once_nxt = 1'b0;
            end
          end else begin
            w_shift_nxt  = {w_bit, r_shift[7:1]};
            w_bitcnt_nxt = r_bitcnt + 3'd1;
            w_ones_nxt   = w_bit ? r_ones + 3'd1 : 3'd0;
            if (r_bitcnt == 3'd7) begin
              w_data_nxt  = w_shift_nxt;
              w_valid_nxt = 1'b1;
            end
          end
        end

        ST_WAIT_IDLE: begin
          if (w_line == LINE_J) begin
            if (r_j_once) begin
              w_state_nxt  = ST_IDLE;
              w_seen_j_nxt = 1'b1;
            end else begin
              w_j_once_nxt = 1'b1;
            end
          end else begin
            w_j_once_nxt = 1'b0;
          end
        end

        default: w_state_nxt = ST_IDLE;
      endcase
    end

    // Own transmitter on the bus: hold off and drop any partial packet
    if (usb_tx_oe) begin
      w_state_nxt   = ST_IDLE;
      w_seen_j_nxt  = 1'b0;
      w_active_nxt  = 1'b0;
      w_valid_nxt   = 1'b0;
      w_eop_nxt     = 1'b0;
      w_error_nxt   = 1'b0;
      w_bitcnt_nxt  = 3'd0;
      w_se0_cnt_nxt = 2'd0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_prev_k  <= 1'b0;
      r_seen_j  <= 1'b0;
      r_j_once  <= 1'b0;
      r_zeros   <= 2'd0;
      r_ones    <= 3'd0;
      r_se0_cnt <= 2'd0;
      r_bitcnt  <= 3'd0;
      r_shift   <= 8'd0;
      r_data    <= 8'd0;
      r_valid   <= 1'b0;
      r_active  <= 1'b0;
      r_eop     <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_prev_k  <= w_prev_k_nxt;
      r_seen_j  <= w_seen_j_nxt;
      r_j_once  <= w_j_once_nxt;
      r_zeros   <= w_zeros_nxt;
      r_ones    <= w_ones_nxt;
      r_se0_cnt <= w_se0_cnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_shift   <= w_shift_nxt;
      r_data    <= w_data_nxt;
      r_valid   <= w_valid_nxt;
      r_active  <= w_active_nxt;
      r_eop     <= w_eop_nxt;
      r_error   <= w_error_nxt;
    end
  end

  assign rx_data      = r_data;
  assign rx_valid     = r_valid;
  assign rx_active    = r_active;
  assign rx_eop       = r_eop;
  assign rx_error     = r_error;
  assign rx_bit_pulse = w_sample & ~usb_tx_oe;

endmodule

// File: tb/tb_usb_rx.sv
// Directed bench for usb_rx: a table of packets plus hand-written corner cases.
module tb_usb_rx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       usb_speed = 1'b0;
  logic       usb_tx_oe = 1'b0;
  logic       usb_rx_dp = 1'b0;
  logic       usb_rx_dm = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, rx_active, rx_eop, rx_error, rx_bit_pulse;

  usb_rx dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usb_speed    (usb_speed),
    .usb_tx_oe    (usb_tx_oe),
    .usb_rx_dp    (usb_rx_dp),
    .usb_rx_dm    (usb_rx_dm),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_active    (rx_active),
    .rx_eop       (rx_eop),
    .rx_error     (rx_error),
    .rx_bit_pulse (rx_bit_pulse)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  // Output monitor: sole writer of the event counters
  int         n_valid = 0, n_eop = 0, n_err = 0, n_act = 0, n_bp = 0, n_excl = 0;
  logic [7:0] got [0:63];

  always @(negedge clk) begin
    if (rx_valid) begin
      if (n_valid < 64) got[n_valid] = rx_data;
      n_valid = n_valid + 1;
    end
    if (rx_eop)       n_eop = n_eop + 1;
    if (rx_error)     n_err = n_err + 1;
    if (rx_active)    n_act = n_act + 1;
    if (rx_bit_pulse) n_bp  = n_bp + 1;
    if ((rx_valid && rx_eop) || (rx_error && rx_eop)) begin
      n_excl = n_excl + 1;
      $display("FAIL exclusive pulses at %0t: valid=%0b eop=%0b error=%0b", $time, rx_valid, rx_eop, rx_error);
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Line driver: 0 = SE0, 1 = J, 2 = K
  int cur = 1;

  function automatic int bclks();
    return usb_speed ? 4 : 32;
  endfunction

  task automatic hold(input int st, input int nbits);
    case (st)
      0:       begin usb_rx_dp = 1'b0;       usb_rx_dm = 1'b0;       end
      1:       begin usb_rx_dp = usb_speed;  usb_rx_dm = !usb_speed; end
      default: begin usb_rx_dp = !usb_speed; usb_rx_dm = usb_speed;  end
    endcase
    repeat (nbits * bclks()) @(posedge clk);
    #1;
  endtask

  task automatic send_nrzi(input logic b);
    if (!b) cur = (cur == 1) ? 2 : 1;
    hold(cur, 1);
  endtask

  task automatic send_idle(input int n);
    cur = 1;
    hold(1, n);
  endtask

  task automatic send_sync();
    for (int i = 0; i < 7; i++) send_nrzi(1'b0);
    send_nrzi(1'b1);
  endtask

  // LSB-first bits; a 0 is inserted after six 1s when stuff is set
  task automatic send_data(input logic [31:0] bits, input int nbits, input logic stuff);
    int ones;
    ones = 0;
    for (int i = 0; i < nbits; i++) begin
      send_nrzi(bits[i]);
      ones = bits[i] ? ones + 1 : 0;
      if (stuff && ones == 6) begin
        send_nrzi(1'b0);
        ones = 0;
      end
    end
  endtask

  task automatic send_eop();
    hold(0, 2);
    cur = 1;
    hold(1, 1);
  endtask

  typedef struct {
    logic        spd;
    int          nbits;
    logic [31:0] bits;
    int          nv;
    logic [7:0]  e0;
    logic [7:0]  e1;
    int          eop;
    int          err;
  } vec_t;

  vec_t tv [6];
  int   bv, be, br, ba, bb;

  task automatic snap();
    bv = n_valid; be = n_eop; br = n_err; ba = n_act; bb = n_bp;
  endtask

  initial begin
    tv[0] = '{1'b0, 16, 32'h0000124B, 2, 8'h4B, 8'h12, 1, 0};
    tv[1] = '{1'b1, 16, 32'h000000FF, 2, 8'hFF, 8'h00, 1, 0};
    tv[2] = '{1'b0, 11, 32'h000007A5, 1, 8'hA5, 8'h00, 0, 1};
    tv[3] = '{1'b1,  8, 32'h0000005A, 1, 8'h5A, 8'h00, 1, 0};
    tv[4] = '{1'b1, 16, 32'h00003F7E, 2, 8'h7E, 8'h3F, 1, 0};
    tv[5] = '{1'b0,  8, 32'h00000000, 1, 8'h00, 8'h00, 1, 0};

    // Reset state
    repeat (4) @(posedge clk);
    #1;
    chk("rst rx_data", rx_data, 0);
    chk("rst rx_valid", rx_valid, 0);
    chk("rst rx_active", rx_active, 0);
    chk("rst rx_eop", rx_eop, 0);
    chk("rst rx_error", rx_error, 0);
    chk("rst rx_bit_pulse", rx_bit_pulse, 0);
    rst_n = 1'b1;
    send_idle(8);

    // Table-driven packets
    for (int i = 0; i < 6; i++) begin
      usb_speed = tv[i].spd;
      send_idle(8);
      snap();
      send_sync();
      send_data(tv[i].bits, tv[i].nbits, 1'b1);
      send_eop();
      send_idle(4);
      chk($sformatf("v%0d valid count", i), n_valid - bv, tv[i].nv);
      chk($sformatf("v%0d byte0", i), got[bv], tv[i].e0);
      if (tv[i].nv > 1) chk($sformatf("v%0d byte1", i), got[bv + 1], tv[i].e1);
      chk($sformatf("v%0d eop count", i), n_eop - be, tv[i].eop);
      chk($sformatf("v%0d error count", i), n_err - br, tv[i].err);
      chk($sformatf("v%0d active seen", i), int'((n_act - ba) > 0), 1);
      chk($sformatf("v%0d active at end", i), rx_active, 0);
    end

    // Sample strobe rate on a steady idle line (LS then FS)
    snap();
    repeat (64) @(posedge clk);
    #1;
    chk("ls bit pulses in 64 clk", n_bp - bb, 2);
    usb_speed = 1'b1;
    send_idle(8);
    snap();
    repeat (40) @(posedge clk);
    #1;
    chk("fs bit pulses in 40 clk", n_bp - bb, 10);

    // FS stuff error: seven 1s, no stuff bit
    snap();
    send_sync();
    send_data(32'h7F, 7, 1'b0);
    send_data(32'h0, 1, 1'b0);
    chk("stuff err pulse", n_err - br, 1);
    chk("stuff err active low", rx_active, 0);
    send_data(32'h0, 7, 1'b0);
    send_eop();
    send_idle(8);
    chk("stuff err no valid", n_valid - bv, 0);
    chk("stuff err no eop", n_eop - be, 0);
    snap();
    send_sync();
    send_data(32'h5A, 8, 1'b1);
    send_eop();
    send_idle(4);
    chk("after stuff err valid", n_valid - bv, 1);
    chk("after stuff err byte", got[bv], 8'h5A);
    chk("after stuff err eop", n_eop - be, 1);

    // FS long SE0 without J
    snap();
    send_sync();
    send_data(32'hA5, 8, 1'b1);
    hold(0, 6);
    send_idle(8);
    chk("long se0 valid", n_valid - bv, 1);
    chk("long se0 byte", got[bv], 8'hA5);
    chk("long se0 error", n_err - br, 1);
    chk("long se0 no eop", n_eop - be, 0);
    chk("long se0 active end", rx_active, 0);

    // Local transmitter enabled during a valid packet
    usb_tx_oe = 1'b1;
    snap();
    send_idle(4);
    send_sync();
    send_data(32'h5A, 8, 1'b1);
    send_eop();
    send_idle(4);
    chk("tx_oe valid", n_valid - bv, 0);
    chk("tx_oe eop", n_eop - be, 0);
    chk("tx_oe active", n_act - ba, 0);
    chk("tx_oe error", n_err - br, 0);
    chk("tx_oe bit pulses", n_bp - bb, 0);
    usb_tx_oe = 1'b0;
    send_idle(8);

    // LS reset mid-byte, then a fresh packet
    usb_speed = 1'b0;
    send_idle(8);
    send_sync();
    send_data(32'h5, 4, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid rst rx_data", rx_data, 0);
    chk("mid rst rx_valid", rx_valid, 0);
    chk("mid rst rx_active", rx_active, 0);
    chk("mid rst rx_eop", rx_eop, 0);
    chk("mid rst rx_error", rx_error, 0);
    chk("mid rst rx_bit_pulse", rx_bit_pulse, 0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    snap();
    send_data(32'hF, 4, 1'b0);
    send_eop();
    send_idle(8);
    chk("post rst ignored valid", n_valid - bv, 0);
    chk("post rst ignored eop", n_eop - be, 0);
    chk("post rst ignored error", n_err - br, 0);
    snap();
    send_sync();
    send_data(32'h5A, 8, 1'b1);
    send_eop();
    send_idle(4);
    chk("post rst valid", n_valid - bv, 1);
    chk("post rst byte", got[bv], 8'h5A);
    chk("post rst eop", n_eop - be, 1);
    chk("post rst error", n_err - br, 0);

    chk("exclusive pulse violations", n_excl, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/usb_rx.md
USB_RX -- requirements
Module: usb_rx

Interface
REQ-001 The block SHALL have these ports, clock and reset first:
- clk  in  1  48 MHz clock, the only clock.
- rst_n  in  1  asynchronous active-low reset.
- usb_speed  in  1  0 = low speed (1.5 Mbps, 32 clk/bit), 1 = full speed (12 Mbps, 4 clk/bit).
- usb_tx_oe  in  1  local transmitter driving the bus; receiver held in IDLE while high.
- usb_rx_dp  in  1  raw D+ pad input, asynchronous.
- usb_rx_dm  in  1  raw D- pad input, asynchronous.
- rx_data  out  8  received byte, LSB first on the wire; valid only with rx_valid.
- rx_valid  out  1  one-clk pulse per completed byte.
- rx_active  out  1  high from SYNC accepted until EOP or error.
- rx_eop  out  1  one-clk pulse on a valid EOP that ends an active packet.
- rx_error  out  1  one-clk pulse on a bit-stuff error or a non-byte-aligned EOP.
- rx_bit_pulse  out  1  one-clk pulse at each mid-bit sample point.

REQ-002 Parameters: LS_BIT_CLKS, default 32, low-speed clocks per bit; FS_BIT_CLKS, default 4, full-speed clocks per bit.

Function
REQ-003 dp and dm SHALL each pass through a 2-flop synchronizer; all logic uses the synchronized values only.
REQ-004 Line states: SE0 = dp=0, dm=0. J = dp=1 at full speed, or dm=1 at low speed. K = the opposite non-SE0 state. dp=dm=1 SHALL be treated as SE0.
REQ-005 Bit timing: a down-counter SHALL reload to half a bit period (LS 16, FS 2) on every J/K transition. At 0 it produces a sample (rx_bit_pulse) and reloads to the full bit period (32 or 4).
REQ-006 NRZI: a sampled J/K equal to the previous sample decodes as 1, a different one as 0.
REQ-007 States SHALL be IDLE, SYNC, DATA, WAIT_IDLE.
REQ-008 IDLE -> SYNC on the first K sample after at least one J sample.
REQ-009 In SYNC, ≥3 consecutive decoded 0s followed by two consecutive K samples (decoded 1) SHALL accept SYNC: assert rx_active and enter DATA.
REQ-010 Any SE0 sample in SYNC SHALL return the block to IDLE with no output pulses.
REQ-011 Bit unstuffing in DATA: after six consecutive decoded 1s, the next bit SHALL be discarded if 0. If it is 1, the block SHALL pulse rx_error, drop rx_active and enter WAIT_IDLE.
REQ-012 Data bits SHALL shift in LSB first. On the 8th kept bit, rx_data updates and rx_valid pulses on the clock after that sample. rx_data holds until the next byte.
REQ-013 EOP: an SE0 sample in DATA followed by a J sample.
- If the kept-bit count mod 8 is 0: pulse rx_eop and drop rx_active on the J sample.
- Otherwise: pulse rx_error instead of rx_eop, then drop rx_active.
- In both cases the next state is IDLE.
REQ-014 An SE0 lasting more than 3 bit times without a following J SHALL drop rx_active, pulse rx_error and enter WAIT_IDLE.
REQ-015 WAIT_IDLE -> IDLE after 2 consecutive J samples.
REQ-016 While usb_tx_oe=1, the state SHALL be forced to IDLE, with rx_active=0 and no pulses. Any partial byte is discarded.
REQ-017 A usb_speed change SHALL take effect at the next counter reload only. Changing speed mid-packet is unsupported; the result is undefined but the block SHALL recover via IDLE.
REQ-018 rx_valid and rx_eop SHALL never assert in the same clk. rx_error and rx_eop are mutually exclusive.

Reset
REQ-019 With rst_n=0, all state SHALL clear asynchronously: state IDLE, synchronizers 0, rx_data=0, and rx_valid, rx_active, rx_eop, rx_error and rx_bit_pulse all 0.
REQ-020 Reset deassertion mid-packet SHALL leave the block in IDLE; the in-flight packet is ignored until the next SYNC.

Structure
REQ-021 The shared package usb_defs SHALL hold:
- the LS/FS clocks-per-bit constants;
- the half-bit reload values;
- the state encoding;
- the line-state encoding (SE0/J/K).
REQ-022 The bit-timing recovery and sampling (REQ-005) SHALL be one sub-module, usb_rx_bitclk. Decode, unstuff, SYNC/EOP detection and byte assembly stay in usb_rx.

Verification
REQ-023 LS, usb_tx driving SYNC then 0x4B, 0x12, then EOP -> rx_valid with 0x4B, then 0x12, then one rx_eop, rx_error never asserted.
REQ-024 FS, byte 0xFF followed by 0x00 (stuffed 0 inserted) -> rx_data 0xFF then 0x00, no rx_error.
REQ-025 FS, seven consecutive 1s with the stuff bit forced to 1 -> rx_error pulse, rx_active=0, no further rx_valid until J idle then a new SYNC.
REQ-026 LS, SYNC plus 11 data bits then EOP -> one rx_valid, then rx_error (not rx_eop) at the EOP J.
REQ-027 rst_n pulsed low mid-byte, then a fresh packet of 0x5A -> all outputs 0 during reset; the fresh packet yields rx_data 0x5A.
REQ-028 usb_tx_oe=1 while a valid packet is on the lines -> no rx_valid, rx_eop or rx_active.
